// File: rtl/fetch_sequencer.sv
// Next-PC sequencer for the LEGv8 fetch stage.
// Owns fetch_pc, arbitrates redirects and drives the IF/ID flush.
module fetch_sequencer #(
  parameter int              ADDR_W       = 64,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int              FLUSH_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              exc_req,
  input  logic [ADDR_W-1:0] exc_vector,
  input  logic              halt_req,
  input  logic              resume,
  output logic [ADDR_W-1:0] fetch_pc,
  output logic              fetch_valid,
  output logic              flush,
  output logic [1:0]        state,
  output logic [15:0]       redirect_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    FLUSH = 2'b01,
    HALT  = 2'b10
  } state_t;

  localparam logic [3:0] FC_LOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            st_q, st_n;
  logic [ADDR_W-1:0] pc_q, pc_n;
  logic [3:0]        fc_q, fc_n;
  logic [15:0]       rc_q, rc_n;
  logic              redir;

  // Register all sequencer state; reset discards any pending flush.
  always_ff @(posedge clock) begin
    if (reset) begin
      st_q <= RUN;
      pc_q <= RESET_PC;
      fc_q <= 4'd0;
      rc_q <= 16'd0;
    end else begin
      st_q <= st_n;
      pc_q <= pc_n;
      fc_q <= fc_n;
      rc_q <= rc_n;
    end
  end

  // Next-PC arbitration: exception, branch, halt, stall, increment.
  always_comb begin
    st_n  = st_q;
    pc_n  = pc_q;
    fc_n  = fc_q;
    redir = 1'b0;
    if (exc_req) begin
      pc_n  = exc_vector;
      st_n  = FLUSH;
      fc_n  = FC_LOAD;
      redir = 1'b1;
    end else begin
      case (st_q)
        RUN: begin
          if (br_taken) begin
            pc_n  = br_target;
            st_n  = FLUSH;
            fc_n  = FC_LOAD;
            redir = 1'b1;
          end else if (halt_req) begin
            st_n = HALT;
          end else if (!stall) begin
            pc_n = pc_q + PC_ONE;
          end
        end
        FLUSH: begin
          if (fc_q == 4'd0) st_n = RUN;
          else              fc_n = fc_q - 4'd1;
        end
        HALT: begin
          if (resume) st_n = RUN;
        end
        default: st_n = RUN;
      endcase
    end
  end

  // Redirect counter sticks at all-ones; one increment per edge max.
  always_comb begin
    rc_n = rc_q;
    if (redir && rc_q != 16'hFFFF) rc_n = rc_q + 16'd1;
  end

  assign fetch_pc     = pc_q;
  assign state        = st_q;
  assign redirect_cnt = rc_q;
  assign fetch_valid  = (st_q == RUN);
  assign flush        = (st_q == FLUSH);

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Next-PC controller for the pipelined LEGv8 fetch stage. It owns the word-addressed fetch PC and arbitrates every PC source: sequential increment, hazard stall, taken branch from EX, exception vector, and halt/resume. It also generates the IF/ID pipeline flush that follows each redirect. Its outputs feed the instruction memory address and the IF/ID register control.

## Interface
Parameters:
- ADDR_W, 64, fetch PC width; word address (+1 per instruction).
- RESET_PC, 0, PC loaded on reset.
- FLUSH_CYCLES, 2, bubble cycles after each redirect; legal range 1..15.

Ports:
- clock  in  1  single clock, all state updates on posedge.
- reset  in  1  synchronous, active-high.
- stall  in  1  hazard unit: hold PC this cycle.
- br_taken  in  1  EX-stage taken branch/jump.
- br_target  in  ADDR_W  branch destination (word address).
- exc_req  in  1  exception request.
- exc_vector  in  ADDR_W  exception handler address.
- halt_req  in  1  level; stop fetching.
- resume  in  1  leave HALT.
- fetch_pc  out  ADDR_W  registered current fetch address.
- fetch_valid  out  1  fetch_pc is a real instruction this cycle.
- flush  out  1  squash IF/ID contents.
- state  out  2  RUN=00, FLUSH=01, HALT=10 (11 unused).
- redirect_cnt  out  16  count of accepted redirects, saturating.

## Operation
- Registers: fetch_pc, state, flush_cnt (4 b), redirect_cnt. All outputs besides these are decoded from state: fetch_valid = (state==RUN); flush = (state==FLUSH).
- Reset values: fetch_pc=RESET_PC, state=RUN, flush_cnt=0, redirect_cnt=0. So fetch_valid=1 and flush=0 on the first cycle after reset.
- Per-edge priority, highest first (reset low):
  1. exc_req (any state, including HALT and FLUSH): fetch_pc<=exc_vector, state<=FLUSH, flush_cnt<=FLUSH_CYCLES-1, redirect_cnt++.
  2. br_taken while state==RUN: fetch_pc<=br_target, state<=FLUSH, flush_cnt<=FLUSH_CYCLES-1, redirect_cnt++. br_taken is ignored in FLUSH (wrong-path) and HALT. stall does not block a redirect.
  3. halt_req while state==RUN: state<=HALT, fetch_pc holds. halt_req is not acted on in FLUSH; it takes effect at the first RUN edge.
  4. state==RUN, stall=1: everything holds.
  5. state==RUN, stall=0: fetch_pc<=fetch_pc+1, modulo 2^ADDR_W (all-ones wraps to 0).
- FLUSH:
  - fetch_pc holds the target.
  - stall and halt_req are ignored.
  - If flush_cnt==0, the next state is RUN; otherwise flush_cnt decrements.
- HALT:
  - fetch_pc holds.
  - On resume, state<=RUN; fetch_pc is unchanged, so the held PC is fetched next.
  - halt_req and resume together while in HALT: resume wins.
  - halt_req still high after return to RUN: re-halts on the next edge.
- redirect_cnt: +1 per accepted redirect, sticks at 0xFFFF. exc_req and br_taken in the same cycle count as one.

## Timing
- Sequential: in RUN with stall=0 at edge N, fetch_pc advances by 1 after edge N. Throughput is 1 PC/cycle.
- Redirect sampled at edge N:
  - fetch_pc=target from cycle N+1.
  - flush=1, fetch_valid=0 for cycles N+1..N+FLUSH_CYCLES.
  - fetch_valid=1 with fetch_pc=target at cycle N+FLUSH_CYCLES+1.
  - fetch_pc advances at the following edge if stall=0.
- exc_req during FLUSH restarts the count: the new target is loaded and flush lasts another FLUSH_CYCLES from that edge.
- Simultaneous exc_req+br_taken: exception target wins, branch dropped.
- Simultaneous br_taken+halt_req in RUN: branch wins; halt is taken after the flush completes.
- Reset asserted mid-FLUSH or HALT: all registers return to reset values at that edge. Pending flush and count are discarded.
- No combinational path from inputs to outputs.

## Test plan
- Reset, then stall=0 for 4 cycles: fetch_pc 0,1,2,3,4; fetch_valid=1 throughout; flush=0.
- br_taken=1, br_target=0x40 at PC 5, FLUSH_CYCLES=2: fetch_pc=0x40 next cycle, flush=1 and fetch_valid=0 for 2 cycles, then valid at 0x40, then 0x41; redirect_cnt=1.
- exc_req (vector 0x100) and br_taken (0x40) in the same cycle: fetch_pc=0x100, redirect_cnt +1. Second exc_req (0x200) during FLUSH: fetch_pc=0x200, flush extends 2 cycles from that edge. br_taken during FLUSH: ignored.
- halt_req at PC 7 while stall=1: state=HALT, fetch_pc=7, fetch_valid=0. resume: fetch_valid=1 at PC 7, then 8. exc_req while halted: jumps to vector via FLUSH.
- fetch_pc forced near wrap (RESET_PC=2^64-2): sequence 2^64-2, 2^64-1, 0. Reset asserted mid-FLUSH: fetch_pc=RESET_PC, state=RUN, redirect_cnt=0 next cycle.
- 65,540 back-to-back redirects (FLUSH_CYCLES=1): redirect_cnt saturates at 0xFFFF and holds.
